// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operand-issue and result/flag handshake bundle for seq_alu
interface seq_alu_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c;
  logic             z;
  logic             v;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, c, z, v
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, c, z, v
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered WIDTH-bit ALU with valid/ready handshakes and flags
// ALU_MUL_EN enables the iterative shift-add multiplier (op 111); otherwise op 111 is a NOP.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_MUL_EN
    EXEC = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             v_q, v_d;

  logic             accept;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]     psum;
`endif

  assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.c         = c_q;
  assign bus.z         = z_q;
  assign bus.v         = v_q;
  assign accept        = bus.in_valid & bus.in_ready;
  assign sh            = bus.b[SHW-1:0];

  // Single-cycle ops; the extra wide bit carries carry/borrow/shifted-out bit.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      3'b000: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b001: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'b010: alu_res = bus.a & bus.b;
      3'b011: alu_res = bus.a | bus.b;
      3'b100: alu_res = bus.a ^ bus.b;
      3'b101: begin
        wide    = {1'b0, bus.a} << sh;
        alu_res = wide[WIDTH-1:0];
        alu_c   = wide[WIDTH];
      end
      3'b110: begin
        wide    = {bus.a, 1'b0} >> sh;
        alu_res = wide[WIDTH:1];
        alu_c   = wide[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    v_d      = v_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    psum     = '0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
`ifdef ALU_MUL_EN
          if (bus.op == 3'b111) begin
            mcand_d = bus.a;
            prod_d  = {{WIDTH{1'b0}}, bus.b};
            cnt_d   = '0;
            state_d = EXEC;
          end else
`endif
          begin
            result_d = alu_res;
            c_d      = alu_c;
            v_d      = alu_v;
            z_d      = (alu_res == '0);
            state_d  = DONE;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MUL_EN
      // Multiplier bits live in the low half and retire LSB-first as the product shifts in.
      EXEC: begin
        psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {psum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          result_d = prod_d[WIDTH-1:0];
          c_d      = |prod_d[2*WIDTH-1:WIDTH];
          v_d      = 1'b0;
          z_d      = (prod_d[WIDTH-1:0] == '0);
          state_d  = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      v_q      <= v_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (WIDTH=8) against an arithmetic reference model
module tb_seq_alu;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  vec_t dir_vecs [12];

  function automatic int exp_lat(input int op);
`ifdef ALU_MUL_EN
    return (op == 7) ? W + 1 : 1;
`else
    return 1;
`endif
  endfunction

  // Reference: integer arithmetic on unsigned/signed interpretations of the operands.
  function automatic void model(input int a, input int b, input int op,
                                output int r, output int c, output int z, output int v);
    int sa, sb, t, s;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    s  = b % W;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin t = a + b; r = t % 256; c = (t >= 256); v = ((sa + sb) > 127 || (sa + sb) < -128); end
      1: begin r = (a - b + 256) % 256; c = (a < b); v = ((sa - sb) > 127 || (sa - sb) < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * (1 << s)) % 256; c = (s == 0) ? 0 : ((a >> (W - s)) & 1); end
      6: begin r = a >> s; c = (s == 0) ? 0 : ((a >> (s - 1)) & 1); end
      default: begin
`ifdef ALU_MUL_EN
        t = a * b; r = t % 256; c = (t >= 256);
`else
        r = 0;
`endif
      end
    endcase
    z = (r == 0);
  endfunction

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       output logic [7:0] r, output logic rc, output logic rz, output logic rv,
                       output int lat, output int early_rdy);
    @(negedge clk);
    bus.a = ia; bus.b = ib; bus.op = iop; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = -1;
    early_rdy = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bus.in_ready) early_rdy++;
    end
    r = bus.result; rc = bus.c; rz = bus.z; rv = bus.v;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if ({bus.result, bus.c, bus.z, bus.v} !== 11'd0) begin bad++; $display("FAIL reset_outputs got=%h/%b%b%b want=00/000", bus.result, bus.c, bus.z, bus.v); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_directed;
    logic [7:0] r;
    logic rc, rz, rv;
    int lat, er;
    dir_vecs[0] = {3'd0, 8'h35, 8'hC1, 8'hF6, 1'b0, 1'b0, 1'b0};
    dir_vecs[1] = {3'd0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0};
    dir_vecs[2] = {3'd1, 8'h03, 8'h03, 8'h00, 1'b0, 1'b1, 1'b0};
    dir_vecs[3] = {3'd1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0};
    dir_vecs[4] = {3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    dir_vecs[5] = {3'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
    dir_vecs[6] = {3'd5, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0};
    dir_vecs[7] = {3'd6, 8'h81, 8'hF8, 8'h81, 1'b0, 1'b0, 1'b0};
    dir_vecs[8] = {3'd6, 8'h10, 8'h04, 8'h01, 1'b0, 1'b0, 1'b0};
    dir_vecs[9] = {3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
`ifdef ALU_MUL_EN
    dir_vecs[10] = {3'd7, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0};
    dir_vecs[11] = {3'd7, 8'hF0, 8'h0F, 8'h10, 1'b1, 1'b0, 1'b0};
`else
    dir_vecs[10] = {3'd7, 8'h0F, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0};
    dir_vecs[11] = {3'd7, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0};
`endif
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      issue(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].op, r, rc, rz, rv, lat, er);
      total++; if (lat != exp_lat(int'(dir_vecs[i].op))) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, exp_lat(int'(dir_vecs[i].op))); end
      total++; if (er != 0) begin bad++; $display("FAIL dir%0d_ready_while_busy got=%0d want=0", i, er); end
      total++; if ({r, rc, rz, rv} !== {dir_vecs[i].r, dir_vecs[i].c, dir_vecs[i].z, dir_vecs[i].v})
        begin bad++; $display("FAIL dir%0d_result got=%h c%b z%b v%b want=%h c%b z%b v%b", i, r, rc, rz, rv,
                              dir_vecs[i].r, dir_vecs[i].c, dir_vecs[i].z, dir_vecs[i].v); end
    end
  endtask

  task automatic test_random;
    logic [7:0] r, a, b;
    logic [2:0] op;
    logic rc, rz, rv;
    int lat, er, mr, mc, mz, mv;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 7));
      model(int'(a), int'(b), int'(op), mr, mc, mz, mv);
      issue(a, b, op, r, rc, rz, rv, lat, er);
      total++; if (lat != exp_lat(int'(op)) || er != 0) begin bad++; $display("FAIL rnd%0d_timing lat=%0d early=%0d want lat=%0d early=0", i, lat, er, exp_lat(int'(op))); end
      total++; if ({r, rc, rz, rv} !== {8'(mr), 1'(mc), 1'(mz), 1'(mv)})
        begin bad++; $display("FAIL rnd%0d op%0d a=%h b=%h got=%h c%b z%b v%b want=%h c%0d z%0d v%0d", i, op, a, b, r, rc, rz, rv, mr, mc, mz, mv); end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.a = 8'h01; bus.b = 8'h02; bus.op = 3'd0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, 8'h03})
        begin bad++; $display("FAIL bp_hold%0d got valid=%b ready=%b res=%h want 1/0/03", i, bus.out_valid, bus.in_ready, bus.result); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = 8'hAA; bus.b = 8'h55; bus.op = 3'd4; bus.in_valid = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    total++; if ({bus.out_valid, bus.result, bus.c, bus.z, bus.v} !== {1'b1, 8'hFF, 3'b000})
      begin bad++; $display("FAIL bp_xor got valid=%b res=%h c%b z%b v%b want 1 FF 000", bus.out_valid, bus.result, bus.c, bus.z, bus.v); end
  endtask

  task automatic test_back_to_back;
    int er [8], ec [8], ez [8], ev [8];
    logic [7:0] a, b;
    logic [2:0] op;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++; if ({bus.out_valid, bus.result, bus.c, bus.z, bus.v} !== {1'b1, 8'(er[i-1]), 1'(ec[i-1]), 1'(ez[i-1]), 1'(ev[i-1])})
          begin bad++; $display("FAIL b2b%0d got valid=%b res=%h c%b z%b v%b want 1 %h c%0d z%0d v%0d", i - 1, bus.out_valid, bus.result, bus.c, bus.z, bus.v, er[i-1], ec[i-1], ez[i-1], ev[i-1]); end
      end
      if (i < 8) begin
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
        model(int'(a), int'(b), int'(op), er[i], ec[i], ez[i], ev[i]);
        bus.a = a; bus.b = b; bus.op = op; bus.in_valid = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready got=%b want=1", i, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    @(negedge clk);
`ifdef ALU_MUL_EN
    bus.a = 8'h0F; bus.b = 8'h11; bus.op = 3'd7;
`else
    bus.out_ready = 1'b0;
    bus.a = 8'h21; bus.b = 8'h05; bus.op = 3'd0;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({bus.out_valid, bus.result, bus.c, bus.z, bus.v} !== 12'd0)
      begin bad++; $display("FAIL midreset_clear got valid=%b res=%h c%b z%b v%b want all 0", bus.out_valid, bus.result, bus.c, bus.z, bus.v); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", bus.in_ready); end
    stale = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midreset_stale got=%0d valid cycles want=0", stale); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
